l1d_miss_controller: RTL and testbench

// Sequencing FSM between the CPU load/store port, the L1D tag/data arrays and Main_Memory.

---
 rtl/l1d_miss_controller.sv | 156 +++++++++++++++
 tb/tb_l1d_miss_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_miss_controller.sv
// L1D miss sequencer: serves hits in place, writes back dirty victims, refills 4-beat lines.
// Hit completes two edges after the request is sampled; misses add the memory burst time.
module l1d_miss_controller #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              cpu_load,
   input  logic              cpu_store,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_err,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              tag_hit,
   input  logic              tag_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   output logic [1:0]        arr_word_sel,
   input  logic [DATA_W-1:0] arr_rd_data,
   output logic              arr_wr,
   output logic [DATA_W-1:0] arr_wdata,
   output logic              tag_update,
   output logic              tag_set_dirty,
   output logic              mem_valid,
   output logic              mem_load,
   output logic              mem_store,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_ack_data
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, LOOKUP, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA, UPDATE, DONE, ERR
   } state_t;

   state_t              state, nxt;
   logic [ADDR_W-1:2]   lat_addr;
   logic                lat_store;
   logic [DATA_W-1:0]   lat_wdata;
   logic [1:0]          beat;
   logic [TW-1:0]       timer;
   logic                in_mem, addr_st, data_st, mem_evt, timed_out;
   logic                store_hit, rf_beat;
   logic                unused_bits;

   assign unused_bits = ^{cpu_addr[1:0], victim_addr[3:0]};

   assign addr_st   = (state == WB_ADDR) || (state == RF_ADDR);
   assign data_st   = (state == WB_DATA) || (state == RF_DATA);
   assign in_mem    = addr_st || data_st;
   // Only handshakes relevant to the current state count as progress.
   assign mem_evt   = (addr_st && mem_ack_addr) || (data_st && mem_ready);
   assign timed_out = in_mem && !mem_evt && (timer == TW'(TIMEOUT));

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (cpu_load && cpu_store)      nxt = ERR;
                  else if (cpu_load || cpu_store) nxt = LOOKUP;
         LOOKUP:  if (tag_hit)        nxt = DONE;
                  else if (tag_dirty) nxt = WB_ADDR;
                  else                nxt = RF_ADDR;
         WB_ADDR: if (mem_ack_addr)                nxt = WB_DATA;
         WB_DATA: if (mem_ready && beat == 2'd3)   nxt = RF_ADDR;
         RF_ADDR: if (mem_ack_addr)                nxt = RF_DATA;
         RF_DATA: if (mem_ready && beat == 2'd3)   nxt = UPDATE;
         UPDATE:  nxt = LOOKUP;
         DONE:    nxt = IDLE;
         ERR:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (timed_out)
         nxt = ERR;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         lat_addr   <= '0;
         lat_store  <= 1'b0;
         lat_wdata  <= '0;
         beat       <= 2'd0;
         timer      <= '0;
         cpu_ready  <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= '0;
         tag_update <= 1'b0;
         mem_valid  <= 1'b0;
         mem_load   <= 1'b0;
         mem_store  <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && (cpu_load ^ cpu_store)) begin
            lat_addr  <= cpu_addr[ADDR_W-1:2];
            lat_store <= cpu_store;
            lat_wdata <= cpu_wdata;
         end
         if (state == LOOKUP && tag_hit && !lat_store)
            cpu_rdata <= arr_rd_data;

         if (nxt != state)
            beat <= 2'd0;
         else if (data_st && mem_ready)
            beat <= beat + 2'd1;

         if (nxt != state || mem_evt || !in_mem)
            timer <= '0;
         else
            timer <= timer + 1'b1;

         // Outputs are registered from the next state so they line up with it.
         cpu_ready  <= (nxt == DONE) || (nxt == ERR);
         cpu_err    <= (nxt == ERR);
         tag_update <= (nxt == UPDATE);
         mem_valid  <= (nxt == WB_ADDR) || (nxt == WB_DATA) ||
                       (nxt == RF_ADDR) || (nxt == RF_DATA);
         mem_store  <= (nxt == WB_ADDR) || (nxt == WB_DATA);
         mem_load   <= (nxt == RF_ADDR) || (nxt == RF_DATA);

         if (nxt == WB_ADDR && state == LOOKUP)
            mem_addr <= {victim_addr[ADDR_W-1:4], 4'b0000};
         else if (nxt == WB_ADDR || nxt == WB_DATA)
            mem_addr <= mem_addr;
         else if (nxt == RF_ADDR || nxt == RF_DATA)
            mem_addr <= {lat_addr[ADDR_W-1:4], 4'b0000};
         else
            mem_addr <= '0;
      end
   end

   assign store_hit = (state == LOOKUP) && tag_hit && lat_store;
   assign rf_beat   = (state == RF_DATA) && mem_ready;

   always_comb begin
      arr_word_sel = 2'd0;
      if (state == LOOKUP)
         arr_word_sel = lat_addr[3:2];
      else if (data_st)
         arr_word_sel = beat;
   end

   assign arr_wr        = store_hit || rf_beat;
   assign arr_wdata     = rf_beat ? mem_rdata : (store_hit ? lat_wdata : '0);
   assign tag_set_dirty = store_hit;
   assign mem_wdata     = (state == WB_DATA) ? arr_rd_data : '0;
   assign mem_ack_data  = rf_beat ? (4'b0001 << beat) : 4'b0000;

endmodule

// File: tb/tb_l1d_miss_controller.sv
// Directed bench for l1d_miss_controller with a 4-word data-array model.
module tb_l1d_miss_controller;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 12;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          cpu_load, cpu_store;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ready, cpu_err;
   logic [DW-1:0] cpu_rdata;
   logic          tag_hit, tag_dirty;
   logic [AW-1:0] victim_addr;
   logic [1:0]    arr_word_sel;
   logic [DW-1:0] arr_rd_data;
   logic          arr_wr;
   logic [DW-1:0] arr_wdata;
   logic          tag_update, tag_set_dirty;
   logic          mem_valid, mem_load, mem_store;
   logic [AW-1:0] mem_addr;
   logic          mem_ack_addr, mem_ready;
   logic [DW-1:0] mem_rdata, mem_wdata;
   logic [3:0]    mem_ack_data;

   int n_chk = 0;
   int n_err = 0;
   int n;

   logic [DW-1:0] arr      [0:3];
   logic [DW-1:0] arr_init [0:3];
   logic          arr_load = 1'b0;

   always #5 CLK = ~CLK;

   assign arr_rd_data = arr[arr_word_sel];
   always @(posedge CLK) begin
      if (arr_load) begin
         for (int i = 0; i < 4; i++) arr[i] <= arr_init[i];
      end else if (arr_wr) begin
         arr[arr_word_sel] <= arr_wdata;
      end
   end

   l1d_miss_controller #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .tag_hit(tag_hit), .tag_dirty(tag_dirty), .victim_addr(victim_addr),
      .arr_word_sel(arr_word_sel), .arr_rd_data(arr_rd_data), .arr_wr(arr_wr), .arr_wdata(arr_wdata),
      .tag_update(tag_update), .tag_set_dirty(tag_set_dirty),
      .mem_valid(mem_valid), .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
      .mem_ack_addr(mem_ack_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .mem_ack_data(mem_ack_data)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [31:0] w0, w1, w2, w3);
      arr_init[0] = w0; arr_init[1] = w1; arr_init[2] = w2; arr_init[3] = w3;
      arr_load = 1'b1;
      tick();
      arr_load = 1'b0;
   endtask

   task automatic req(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd);
      cpu_load = ld; cpu_store = st; cpu_addr = a; cpu_wdata = wd;
      tick();
      cpu_load = 1'b0; cpu_store = 1'b0;
   endtask

   initial begin
      RESET_N = 1'b0;
      cpu_load = 0; cpu_store = 0; cpu_addr = '0; cpu_wdata = '0;
      tag_hit = 0; tag_dirty = 0; victim_addr = '0;
      mem_ack_addr = 0; mem_ready = 0; mem_rdata = '0;
      preload(32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
      tick();
      chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_arr_wr", {31'b0, arr_wr}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      RESET_N = 1'b1;
      tick();

      // T1: load hit
      req(1, 0, 32'h0000_0104, 32'h0);
      tag_hit = 1;
      #1;
      chk("t1_word_sel", {30'b0, arr_word_sel}, 32'd1);
      chk("t1_not_ready_yet", {31'b0, cpu_ready}, 32'd0);
      tick();
      chk("t1_ready", {31'b0, cpu_ready}, 32'd1);
      chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("t1_no_mem", {31'b0, mem_valid}, 32'd0);
      tag_hit = 0;
      tick();
      chk("t1_ready_pulse", {31'b0, cpu_ready}, 32'd0);

      // T2: clean load miss with one stall cycle before beat 2
      preload(0, 0, 0, 0);
      req(1, 0, 32'h0000_2008, 32'h0);
      tag_hit = 0; tag_dirty = 0;
      tick();
      chk("t2_mem_valid", {31'b0, mem_valid}, 32'd1);
      chk("t2_mem_load", {31'b0, mem_load}, 32'd1);
      chk("t2_mem_store", {31'b0, mem_store}, 32'd0);
      chk("t2_mem_addr", mem_addr, 32'h0000_2000);
      mem_ack_addr = 1;
      tick();
      mem_ack_addr = 0;
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            mem_ready = 0;
            #1;
            chk("t2_stall_wr", {31'b0, arr_wr}, 32'd0);
            chk("t2_stall_ack", {28'b0, mem_ack_data}, 32'd0);
            tick();
         end
         mem_ready = 1; mem_rdata = 32'hA0 + b;
         #1;
         chk("t2_arr_wr", {31'b0, arr_wr}, 32'd1);
         chk("t2_word_sel", {30'b0, arr_word_sel}, b);
         chk("t2_arr_wdata", arr_wdata, 32'hA0 + b);
         chk("t2_ack_data", {28'b0, mem_ack_data}, 32'd1 << b);
         tick();
      end
      mem_ready = 0;
      chk("t2_tag_update", {31'b0, tag_update}, 32'd1);
      chk("t2_set_dirty", {31'b0, tag_set_dirty}, 32'd0);
      tag_hit = 1;
      tick();
      chk("t2_lookup_sel", {30'b0, arr_word_sel}, 32'd2);
      tick();
      chk("t2_ready", {31'b0, cpu_ready}, 32'd1);
      chk("t2_rdata", cpu_rdata, 32'hA2);
      tag_hit = 0;
      tick();

      // T3: dirty store miss, writeback victim 0x3000 then refill 0x4000
      preload(32'h30, 32'h31, 32'h32, 32'h33);
      req(0, 1, 32'h0000_4004, 32'h5555_AAAA);
      tag_hit = 0; tag_dirty = 1; victim_addr = 32'h0000_3000;
      tick();
      tag_dirty = 0; victim_addr = 32'h0000_7770;
      chk("t3_wb_store", {31'b0, mem_store}, 32'd1);
      chk("t3_wb_load", {31'b0, mem_load}, 32'd0);
      chk("t3_wb_addr", mem_addr, 32'h0000_3000);
      mem_ack_addr = 1;
      tick();
      mem_ack_addr = 0;
      chk("t3_wb_addr_hold", mem_addr, 32'h0000_3000);
      for (int b = 0; b < 4; b++) begin
         mem_ready = 1;
         #1;
         chk("t3_wb_sel", {30'b0, arr_word_sel}, b);
         chk("t3_wb_wdata", mem_wdata, 32'h30 + b);
         tick();
      end
      mem_ready = 0;
      chk("t3_rf_load", {31'b0, mem_load}, 32'd1);
      chk("t3_rf_addr", mem_addr, 32'h0000_4000);
      mem_ack_addr = 1;
      tick();
      mem_ack_addr = 0;
      for (int b = 0; b < 4; b++) begin
         mem_ready = 1; mem_rdata = 32'hB0 + b;
         #1;
         chk("t3_rf_ack", {28'b0, mem_ack_data}, 32'd1 << b);
         tick();
      end
      mem_ready = 0;
      chk("t3_tag_update", {31'b0, tag_update}, 32'd1);
      tag_hit = 1;
      tick();
      chk("t3_merge_wr", {31'b0, arr_wr}, 32'd1);
      chk("t3_merge_data", arr_wdata, 32'h5555_AAAA);
      chk("t3_merge_dirty", {31'b0, tag_set_dirty}, 32'd1);
      chk("t3_merge_sel", {30'b0, arr_word_sel}, 32'd1);
      tick();
      chk("t3_ready", {31'b0, cpu_ready}, 32'd1);
      chk("t3_err", {31'b0, cpu_err}, 32'd0);
      chk("t3_arr_w1", arr[1], 32'h5555_AAAA);
      chk("t3_arr_w2", arr[2], 32'hB2);
      tag_hit = 0;
      tick();

      // T4: address ack withheld in RF_ADDR until timeout
      req(1, 0, 32'h0000_5000, 32'h0);
      tag_hit = 0; tag_dirty = 0;
      tick();
      n = 0;
      while (mem_valid && n < 100) begin
         chk("t4_no_tag_update", {31'b0, tag_update}, 32'd0);
         n++;
         tick();
      end
      chk("t4_wait_cycles", n, TO + 1);
      chk("t4_err", {31'b0, cpu_err}, 32'd1);
      chk("t4_ready", {31'b0, cpu_ready}, 32'd1);
      chk("t4_tag_update", {31'b0, tag_update}, 32'd0);
      tick();
      chk("t4_err_pulse", {31'b0, cpu_err}, 32'd0);

      // T5: reset asserted during refill beat 2
      req(1, 0, 32'h0000_6000, 32'h0);
      tick();
      mem_ack_addr = 1;
      tick();
      mem_ack_addr = 0;
      for (int b = 0; b < 2; b++) begin
         mem_ready = 1; mem_rdata = 32'hC0 + b;
         tick();
      end
      mem_ready = 1; mem_rdata = 32'hC2;
      #1;
      chk("t5_beat2_wr", {31'b0, arr_wr}, 32'd1);
      RESET_N = 1'b0;
      #1;
      chk("t5_rst_wr", {31'b0, arr_wr}, 32'd0);
      chk("t5_rst_ack", {28'b0, mem_ack_data}, 32'd0);
      chk("t5_rst_valid", {31'b0, mem_valid}, 32'd0);
      chk("t5_rst_addr", mem_addr, 32'd0);
      mem_ready = 0;
      tick();
      tick();
      RESET_N = 1'b1;
      preload(32'h11, 32'h22, 32'h33, 32'h44);
      req(1, 0, 32'h0000_0008, 32'h0);
      tag_hit = 1;
      tick();
      chk("t5_post_ready", {31'b0, cpu_ready}, 32'd1);
      chk("t5_post_rdata", cpu_rdata, 32'h33);
      tag_hit = 0;
      tick();

      // T6: load and store together
      req(1, 1, 32'h0000_0010, 32'h0);
      chk("t6_err", {31'b0, cpu_err}, 32'd1);
      chk("t6_ready", {31'b0, cpu_ready}, 32'd1);
      chk("t6_no_mem", {31'b0, mem_valid}, 32'd0);
      chk("t6_no_arr_wr", {31'b0, arr_wr}, 32'd0);
      chk("t6_no_tag", {31'b0, tag_update}, 32'd0);
      tick();
      chk("t6_err_pulse", {31'b0, cpu_err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
